// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and defaults for the frame serializer.
package serial_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PRE,
    S_DATA,
    S_GAP
  } state_t;
  localparam logic [7:0] PREAMBLE_DEF = 8'hA5;
  localparam int GAP_DEF = 2;
endpackage

// File: rtl/bit_shifter.sv
// bit_shifter: LSB-first byte serializer with a 3-bit position counter.
module bit_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_pre,
  input  logic [7:0] preamble,
  input  logic       load_byte,
  input  logic [7:0] byte_in,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       valid_nxt,
  output logic       last,
  output logic       penult
);
  logic [7:0] sr, sr_nxt;
  logic [2:0] cnt, cnt_nxt;
  // The shift register is zeroed whenever no bit is valid, so bit_out is a plain flop bit.
  always_comb begin
    valid_nxt = load_pre || load_byte || (bit_valid && cnt != 3'd7);
    cnt_nxt = (load_pre || load_byte || !valid_nxt) ? 3'd0 : cnt + 3'd1;
    sr_nxt = load_pre ? preamble : load_byte ? byte_in : valid_nxt ? {1'b0, sr[7:1]} : 8'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      cnt <= '0;
      bit_valid <= 1'b0;
    end else begin
      sr <= sr_nxt;
      cnt <= cnt_nxt;
      bit_valid <= valid_nxt;
    end
  end
  assign bit_out = sr[0];
  assign last = bit_valid && cnt == 3'd7;
  assign penult = bit_valid && cnt == 3'd6;
endmodule

// File: rtl/frame_serializer.sv
// frame_serializer: frames a byte stream as preamble + payload bits for a downstream scrambler.
module frame_serializer
  import serial_pkg::*;
#(
  parameter logic [7:0] PREAMBLE = PREAMBLE_DEF,
  parameter int GAP_CYCLES = GAP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] frame_len,
  input  logic [6:0] seed_in,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       load,
  output logic [6:0] seed,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       busy,
  output logic       underrun
);
  state_t state, state_nxt;
  logic [7:0] len_q, acc, sent, hold_data, acc_nxt, sent_nxt;
  logic [3:0] gap_cnt;
  logic hold_full, hold_full_nxt;
  logic go, hs, need, load_byte, byp, stalled;
  logic sh_last, sh_penult, vld_nxt, need_nxt, ready_nxt, underrun_nxt;
  always_comb begin
    go = state == S_IDLE && start && frame_len != 8'd0;
    hs = byte_valid && byte_ready;
    need = (state == S_PRE || state == S_DATA) && (bit_valid ? sh_last && sent < len_q : 1'b1);
    load_byte = need && (hold_full || hs);
    byp = load_byte && !hold_full;
    stalled = state == S_DATA && !bit_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = go ? S_LOAD : S_IDLE;
      S_LOAD:  state_nxt = S_PRE;
      S_PRE:   state_nxt = sh_last ? S_DATA : S_PRE;
      S_DATA:  state_nxt = sh_last && sent == len_q ? S_GAP : S_DATA;
      S_GAP:   state_nxt = gap_cnt == 4'(GAP_CYCLES - 1) ? S_IDLE : S_GAP;
      default: state_nxt = S_IDLE;
    endcase
  end
  // Outputs are registered, so each is derived from the values the next cycle will hold.
  always_comb begin
    acc_nxt = go ? 8'd0 : acc + {7'd0, hs};
    sent_nxt = go ? 8'd0 : sent + {7'd0, load_byte};
    hold_full_nxt = (hold_full && !load_byte) || (hs && !byp);
    need_nxt = vld_nxt ? sh_penult && sent_nxt < len_q : state_nxt == S_DATA;
    ready_nxt = (state_nxt == S_PRE || state_nxt == S_DATA) && acc_nxt < len_q &&
                (!hold_full_nxt || need_nxt);
    underrun_nxt = state_nxt == S_DATA && !vld_nxt && !stalled;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0;
      acc <= '0;
      sent <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
      gap_cnt <= '0;
      byte_ready <= 1'b0;
      load <= 1'b0;
      seed <= '0;
      busy <= 1'b0;
      underrun <= 1'b0;
    end else begin
      len_q <= go ? frame_len : len_q;
      acc <= acc_nxt;
      sent <= sent_nxt;
      hold_full <= hold_full_nxt;
      hold_data <= (hs && !byp) ? byte_data : hold_data;
      gap_cnt <= state == S_GAP ? gap_cnt + 4'd1 : 4'd0;
      byte_ready <= ready_nxt;
      load <= go;
      seed <= go ? seed_in : 7'd0;
      busy <= state_nxt != S_IDLE;
      underrun <= underrun_nxt;
    end
  end
  bit_shifter u_shifter (
    .clk(clk),
    .rst(rst),
    .load_pre(state == S_LOAD),
    .preamble(PREAMBLE),
    .load_byte(load_byte),
    .byte_in(hold_full ? hold_data : byte_data),
    .bit_out(bit_out),
    .bit_valid(bit_valid),
    .valid_nxt(vld_nxt),
    .last(sh_last),
    .penult(sh_penult)
  );
endmodule

// File: doc/frame_serializer.md
FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; every output is registered.
REQ-002 Parameter PREAMBLE, default 8'hA5, SHALL be the sync byte sent at the start of every frame.
REQ-003 Parameter GAP_CYCLES, default 2, SHALL be the number of idle cycles after each frame (legal range 1-15).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  frame request, sampled only in IDLE.
REQ-007 frame_len  in  8  payload bytes per frame, sampled with start.
REQ-008 seed_in  in  7  scrambler seed for this frame, sampled with start.
REQ-009 byte_data  in  8  payload byte.
REQ-010 byte_valid  in  1  byte_data is valid.
REQ-011 byte_ready  out  1  block accepts byte_data this cycle.
REQ-012 load  out  1  one-cycle pulse telling the downstream scrambler to reload its LFSR.
REQ-013 seed  out  7  seed to reload; valid while load=1.
REQ-014 bit_out  out  1  serial data to the scrambler's din.
REQ-015 bit_valid  out  1  bit_out valid; drives the scrambler's din_valid.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 underrun  out  1  one-cycle pulse: a payload bit was due but no byte was buffered.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, PREAMBLE, DATA and GAP.
REQ-019 IDLE->LOAD SHALL occur when start=1 and frame_len!=0; a start with frame_len=0 SHALL be ignored.
REQ-020 In LOAD, for exactly one cycle, load=1 and seed=latched seed_in, then PREAMBLE; bit_valid=0 in LOAD.
REQ-021 PREAMBLE SHALL emit the 8 PREAMBLE bits LSB-first on 8 consecutive cycles with bit_valid=1, then DATA.
REQ-022 Timing: start at cycle N gives load at N+1, preamble bit0 at N+2, payload bit0 at N+10 if a byte is buffered.
REQ-023 A one-byte holding register SHALL be filled by a handshake when byte_valid and byte_ready are both high.
REQ-024 byte_ready=1 in PREAMBLE or DATA only while the holding register is empty or being emptied this cycle, and accepted bytes < latched frame_len.
REQ-025 Each payload byte SHALL be shifted out LSB-first, one bit per cycle, with bit_valid=1.
REQ-026 At a byte boundary, if the holding register is empty: bit_valid=0, underrun pulses once per stall episode, and the state stays DATA until a byte arrives.
REQ-027 A byte accepted in a stall cycle SHALL be emitted starting the next cycle.
REQ-028 After the last bit of byte frame_len, the FSM SHALL enter GAP for GAP_CYCLES cycles (bit_valid=0, byte_ready=0), then IDLE.
REQ-029 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-030 The byte counter SHALL be 8 bits; frame_len=255 SHALL be supported with no wrap.
REQ-031 When bit_valid=0, bit_out SHALL be 0.

Reset
REQ-032 rst=1 SHALL force IDLE with load, seed, bit_out, bit_valid, byte_ready, busy and underrun at 0, counters at 0 and the holding register emptied.
REQ-033 Reset mid-frame SHALL abort the frame with no further bit_valid; load SHALL NOT be re-issued until a new start.

Structure
REQ-034 State encoding, PREAMBLE default and GAP_CYCLES default SHALL live in shared package serial_pkg.
REQ-035 The bit shifter with its 3-bit bit counter SHALL be one sub-module, bit_shifter; the FSM and handshake stay in the top.

Verification
REQ-036 start, frame_len=1, seed_in=7'h5A, byte 8'h3C already valid -> load at N+1 with seed=7'h5A; bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0; GAP; busy low at N+20.
REQ-037 frame_len=3 with bytes continuously valid -> 24 contiguous payload bits, exactly 3 handshakes, underrun never asserted.
REQ-038 Second byte delayed 5 cycles -> bit_valid=0 for 5 cycles, a single underrun pulse, payload resumes intact.
REQ-039 start with frame_len=0, and start pulsed during PREAMBLE -> neither causes load or a new frame.
REQ-040 rst asserted during DATA -> next cycle all outputs 0; a subsequent start gives a normal frame.
REQ-041 The output fed through the downstream scrambler and a reference descrambler -> recovered bits equal PREAMBLE+payload.
